xc_aessub_seq: RTL and testbench

Iterative AES SubBytes functional unit implementing the `xc.aessub.{enc,encrot,dec,decrot}` instructions inside the XCrypto execute stage. It gathers four bytes from `rs1`/`rs2`, passes them through a single shared forward/inverse S-box one byte per cycle, optionally rotates the result, and returns it through a valid/ready handshake. It is the sequential datapath that the combinational `xc_aessub_checker` model is compared against in the rvfi flow.

---
 rtl/xc_aessub_pkg.sv | 26 ++
 rtl/xc_aes_sbox.sv | 49 ++++
 rtl/xc_aessub.sv | 98 +++++++++
 tb/tb_xc_aessub_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/xc_aessub_pkg.sv
// xc_aessub_pkg: shared FSM state, byte-gather lanes and rotation helpers for the AES SubBytes unit
package xc_aessub_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int LANE_W = 8;
    localparam int ROT_AMT = 8;
    // odd byte lanes come from rs2, even byte lanes from rs1
    localparam logic [3:0] LANE_FROM_RS2 = 4'b1010;

    function automatic logic [7:0] gather_byte(input logic [31:0] rs1, input logic [31:0] rs2, input logic [1:0] idx);
        logic [31:0] src;
        src = LANE_FROM_RS2[idx] ? rs2 : rs1;
        return src[LANE_W * idx +: LANE_W];
    endfunction

    // result lane a substituted byte lands in, so rotation costs no extra pass
    function automatic logic [1:0] dest_lane(input logic [1:0] idx, input logic rot);
        return rot ? idx + 2'(ROT_AMT / LANE_W) : idx;
    endfunction

    function automatic logic [31:0] rotate_word(input logic [31:0] w, input logic rot);
        return rot ? {w[31 - ROT_AMT:0], w[31 -: ROT_AMT]} : w;
    endfunction

endpackage

// File: rtl/xc_aes_sbox.sv
// xc_aes_sbox: combinational AES forward/inverse S-box, enc=1 selects the forward table
module xc_aes_sbox (
    input  logic       enc,
    input  logic [7:0] data,
    output logic [7:0] sub
);

    localparam logic [0:255][7:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // table lookup in the selected direction
    always_comb sub = enc ? FWD[data] : INV[data];

endmodule

// File: rtl/xc_aessub.sv
// xc_aessub_seq: iterative AES SubBytes unit; define XC_AESSUB_FAST_EN for four S-boxes and a single BUSY cycle
module xc_aessub_seq
    import xc_aessub_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] result
);

    state_t state, state_nx;
    logic [31:0] op1, op2;
    logic op_enc, op_rot;
    logic last;

`ifdef XC_AESSUB_FAST_EN
    logic [31:0] word;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        xc_aes_sbox u_sbox (
            .enc  (op_enc),
            .data (gather_byte(op1, op2, 2'(g))),
            .sub  (word[LANE_W * g +: LANE_W])
        );
    end

    assign last = 1'b1;
`else
    logic [1:0] cnt;
    logic [7:0] byte_in, byte_out;

    assign byte_in = gather_byte(op1, op2, cnt);
    assign last = cnt == 2'd3;

    xc_aes_sbox u_sbox (
        .enc  (op_enc),
        .data (byte_in),
        .sub  (byte_out)
    );
`endif

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // next state: a dropped valid while BUSY aborts back to IDLE
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (valid) state_nx = BUSY;
            BUSY:    if (!valid) state_nx = IDLE;
                     else if (last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // operand capture, substitution into the result register and the registered ready pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op1 <= '0;
            op2 <= '0;
            op_enc <= 1'b0;
            op_rot <= 1'b0;
            result <= '0;
            ready <= 1'b0;
`ifndef XC_AESSUB_FAST_EN
            cnt <= '0;
`endif
        end else begin
            ready <= state == DONE;
            if (state == IDLE && valid) begin
                op1 <= rs1;
                op2 <= rs2;
                op_enc <= enc;
                op_rot <= rot;
`ifndef XC_AESSUB_FAST_EN
                cnt <= '0;
`endif
            end
            if (state == BUSY && valid) begin
`ifdef XC_AESSUB_FAST_EN
                result <= rotate_word(word, op_rot);
`else
                result[LANE_W * dest_lane(cnt, op_rot) +: LANE_W] <= byte_out;
                cnt <= cnt + 2'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_xc_aessub_seq.sv
// tb_xc_aessub_seq: randomized self-checking bench against a GF(2^8)-derived S-box model
module tb_xc_aessub_seq;

    logic clock = 1'b0;
    logic reset, valid, enc, rot, ready;
    logic [31:0] rs1, rs2, result;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] fwd [256];
    logic [7:0] inv [256];

`ifdef XC_AESSUB_FAST_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 6;
`endif

    xc_aessub_seq dut (
        .clock  (clock),
        .reset  (reset),
        .valid  (valid),
        .rs1    (rs1),
        .rs2    (rs2),
        .enc    (enc),
        .rot    (rot),
        .ready  (ready),
        .result (result)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic build_tables();
        logic [7:0] ai, s;
        for (int a = 0; a < 256; a++) begin
            ai = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) ai = 8'(b);
            s = ai ^ rotl8(ai, 1) ^ rotl8(ai, 2) ^ rotl8(ai, 3) ^ rotl8(ai, 4) ^ 8'h63;
            fwd[a] = s;
            inv[s] = 8'(a);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic e, input logic r);
        logic [7:0] bv, s [4];
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            bv = (i % 2 == 0) ? a[8 * i +: 8] : b[8 * i +: 8];
            s[i] = e ? fwd[bv] : inv[bv];
        end
        w = {s[3], s[2], s[1], s[0]};
        return r ? {w[23:0], w[31:24]} : w;
    endfunction

    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic e, input logic r,
                          input bit scramble, input string tag);
        logic [31:0] exp, held;
        int cyc;
        exp = model(a, b, e, r);
        @(negedge clock);
        rs1 = a; rs2 = b; enc = e; rot = r; valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (scramble && cyc == 1) begin
                rs1 = $urandom; rs2 = $urandom; enc = ~e; rot = ~r;
            end
        end while (ready !== 1'b1 && cyc < 20);
        valid = 1'b0;
        n_cmp++;
        if (cyc !== LAT) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles, want %0d", tag, cyc, LAT);
        end
        n_cmp++;
        if (result !== exp) begin
            n_bad++;
            $display("FAIL %s result: got %h, want %h", tag, result, exp);
        end
        held = result;
        @(negedge clock);
        n_cmp++;
        if (ready !== 1'b0 || result !== held) begin
            n_bad++;
            $display("FAIL %s pulse: ready=%b result=%h, want ready=0 result=%h", tag, ready, result, held);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 1'b0; rs1 = '0; rs2 = '0; enc = 1'b0; rot = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (ready !== 1'b0 || result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset: ready=%b result=%h, want 0/00000000", ready, result);
        end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (ready !== 1'b0 || result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_release: ready=%b result=%h, want 0/00000000", ready, result);
        end
    endtask

    task automatic test_directed();
        do_req(32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, "fwd_zero");
        n_cmp++;
        if (result !== 32'h63636363) begin
            n_bad++;
            $display("FAIL fwd_zero_const: got %h, want 63636363", result);
        end
        do_req(32'h00530001, 32'h7c006300, 1'b1, 1'b0, 1'b0, "fwd_mixed");
        n_cmp++;
        if (result !== 32'h10edfb7c) begin
            n_bad++;
            $display("FAIL fwd_mixed_const: got %h, want 10edfb7c", result);
        end
        do_req(32'h00530001, 32'h7c006300, 1'b1, 1'b1, 1'b0, "fwd_rot");
        n_cmp++;
        if (result !== 32'hedfb7c10) begin
            n_bad++;
            $display("FAIL fwd_rot_const: got %h, want edfb7c10", result);
        end
        do_req(32'h00000063, 32'h00007c00, 1'b0, 1'b0, 1'b0, "inv");
        n_cmp++;
        if (result !== 32'h52520100) begin
            n_bad++;
            $display("FAIL inv_const: got %h, want 52520100", result);
        end
        do_req(32'h00000063, 32'h00007c00, 1'b0, 1'b1, 1'b0, "inv_rot");
    endtask

    task automatic test_operand_change();
        do_req(32'h12345678, 32'h9abcdef0, 1'b1, 1'b1, 1'b1, "scramble_fwd");
        do_req(32'hdeadbeef, 32'hcafef00d, 1'b0, 1'b0, 1'b1, "scramble_inv");
    endtask

    task automatic test_abort();
        bit seen;
        @(negedge clock);
        rs1 = 32'h11223344; rs2 = 32'h55667788; enc = 1'b1; rot = 1'b0; valid = 1'b1;
        repeat (LAT == 3 ? 1 : 2) @(negedge clock);
        valid = 1'b0;
        seen = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clock);
            if (ready === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_ready: got ready pulse=%b, want 0", seen);
        end
        do_req(32'h0badc0de, 32'h600dcafe, 1'b1, 1'b1, 1'b0, "after_abort");
        @(negedge clock);
        rs1 = 32'h01020304; rs2 = 32'h05060708; enc = 1'b0; rot = 1'b1; valid = 1'b1;
        @(negedge clock);
        valid = 1'b0;
        do_req(32'hfeedface, 32'h13579bdf, 1'b0, 1'b1, 1'b0, "reraise_after_abort");
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        rs1 = 32'ha5a5a5a5; rs2 = 32'h5a5a5a5a; enc = 1'b1; rot = 1'b1; valid = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid: ready=%b result=%h, want 0/00000000", ready, result);
        end
        valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (ready !== 1'b0 || result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_hold: ready=%b result=%h, want 0/00000000", ready, result);
        end
        do_req(32'h00530001, 32'h7c006300, 1'b1, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            do_req($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    endtask

    initial begin
        build_tables();
        test_reset();
        test_directed();
        test_operand_change();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
